// File: rtl/writeback_arbiter_pkg.sv
// Core-wide constants and types shared by the writeback path.
package writeback_arbiter_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;

  localparam logic [REG_IDX_W-1:0] X0_IDX = '0;

  // Which producer owns the register-file write port this cycle.
  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_FIFO,
    WB_BYPASS
  } wb_src_e;

  // x0 is hardwired to zero, so writes to it are swallowed.
  function automatic logic is_x0(input logic [REG_IDX_W-1:0] rd);
    return rd == X0_IDX;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding load results that lost the write port.
// The head entry is read combinationally because the consumer registers it.
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Overflow/underflow requests are ignored rather than corrupting state.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and occupancy arithmetic; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // Control state; reset discards any buffered entries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: validity is tracked entirely by count_q.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Arbitrates the single register-file write port between the ALU (always
// wins) and load results (bypassed when possible, otherwise buffered), and
// tracks outstanding loads in a per-register pending scoreboard.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int LSU_DEPTH = 2,
  parameter int XLEN      = writeback_arbiter_pkg::XLEN
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alu_valid,
  input  logic [REG_IDX_W-1:0] alu_rd,
  input  logic [XLEN-1:0]      alu_data,
  input  logic                 lsu_valid,
  output logic                 lsu_ready,
  input  logic [REG_IDX_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]      lsu_data,
  input  logic                 issue_en,
  input  logic [REG_IDX_W-1:0] issue_rd,
  output logic                 rf_write_en,
  output logic [REG_IDX_W-1:0] rf_write_addr,
  output logic [XLEN-1:0]      rf_write_data,
  output logic [NUM_REGS-1:0]  pending,
  output logic                 alu_stall
);

  localparam int ENTRY_W = REG_IDX_W + XLEN;
  localparam int CNT_W   = $clog2(LSU_DEPTH) + 1;

  logic                 lsu_accept;
  logic                 fifo_push, fifo_pop;
  logic                 fifo_full, fifo_empty;
  logic [CNT_W-1:0]     fifo_count;
  logic [ENTRY_W-1:0]   fifo_head;
  wb_src_e              wb_src;
  logic                 load_wr;

  logic                 wr_en_q, wr_en_d;
  logic [REG_IDX_W-1:0] wr_addr_q, wr_addr_d;
  logic [XLEN-1:0]      wr_data_q, wr_data_d;
  logic [NUM_REGS-1:0]  pending_q, pending_d;

  // Ready/stall depend only on registered occupancy, never on this
  // cycle's ALU activity, so there is no combinational path through them.
  assign lsu_ready  = (fifo_count < CNT_W'(LSU_DEPTH));
  assign alu_stall  = fifo_full;
  assign lsu_accept = lsu_valid && lsu_ready;

  wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (LSU_DEPTH)
  ) u_load_buf (
    .clk     (clk),
    .reset   (reset),
    .push    (fifo_push),
    .wr_data ({lsu_rd, lsu_data}),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Port owner: ALU first, then the oldest buffered load, then a bypass.
  // A buffered entry always drains before a fresh load to keep order.
  always_comb begin
    wb_src    = WB_NONE;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    if (alu_valid) begin
      wb_src    = WB_ALU;
      fifo_push = lsu_accept;
    end else if (!fifo_empty) begin
      wb_src    = WB_FIFO;
      fifo_pop  = 1'b1;
      fifo_push = lsu_accept;
    end else if (lsu_accept) begin
      wb_src    = WB_BYPASS;
    end
  end

  // Select the write payload; x0 targets are consumed without a strobe.
  always_comb begin
    wr_addr_d = '0;
    wr_data_d = '0;
    case (wb_src)
      WB_ALU: begin
        wr_addr_d = alu_rd;
        wr_data_d = alu_data;
      end
      WB_FIFO: begin
        {wr_addr_d, wr_data_d} = fifo_head;
      end
      WB_BYPASS: begin
        wr_addr_d = lsu_rd;
        wr_data_d = lsu_data;
      end
      default: ;
    endcase
    wr_en_d = (wb_src != WB_NONE) && !is_x0(wr_addr_d);
    load_wr = (wb_src == WB_FIFO) || (wb_src == WB_BYPASS);
  end

  // Scoreboard next state: a new issue to the same register outranks the
  // clear from a completing load, and x0 is never tracked.
  assign pending_d[0] = 1'b0;
  for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_pending
    assign pending_d[gi] =
        (issue_en && (issue_rd == REG_IDX_W'(gi))) ||
        (pending_q[gi] && !(load_wr && (wr_addr_d == REG_IDX_W'(gi))));
  end

  // Output write-port register and scoreboard state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      pending_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      pending_q <= pending_d;
    end
  end

  assign rf_write_en   = wr_en_q;
  assign rf_write_addr = wr_addr_q;
  assign rf_write_data = wr_data_q;
  assign pending       = pending_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: a scoreboard queue holds the
// register writes in the order they must appear; scenario tasks also check
// cycle timing, back-pressure and the pending map inline.
module tb_writeback_arbiter;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic        rf_write_en;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_data;
  logic [31:0] pending;
  logic        alu_stall;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;

  writeback_arbiter #(.LSU_DEPTH(2), .XLEN(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .alu_valid     (alu_valid),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .lsu_valid     (lsu_valid),
    .lsu_ready     (lsu_ready),
    .lsu_rd        (lsu_rd),
    .lsu_data      (lsu_data),
    .issue_en      (issue_en),
    .issue_rd      (issue_rd),
    .rf_write_en   (rf_write_en),
    .rf_write_addr (rf_write_addr),
    .rf_write_data (rf_write_data),
    .pending       (pending),
    .alu_stall     (alu_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // Scoreboard monitor: every strobed write must match the queue head.
  always @(posedge clk) begin
    #2;
    if (rf_write_en === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_write: got x%0d=%h, required no write", rf_write_addr, rf_write_data);
      end else begin
        wr_t exp;
        exp = sb.pop_front();
        if ({rf_write_addr, rf_write_data} !== {exp.addr, exp.data}) begin
          errors++;
          $display("FAIL sb_write: got x%0d=%h, required x%0d=%h", rf_write_addr, rf_write_data, exp.addr, exp.data);
        end else begin
          $display("write x%0d=%h ok", rf_write_addr, rf_write_data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    issue_en  = 1'b0; issue_rd = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    @(posedge clk);
    step();
    checks++;
    if ({rf_write_en, rf_write_addr, rf_write_data} !== 38'd0) begin
      errors++;
      $display("FAIL reset_write_port: got en=%b addr=%0d data=%h, required all 0", rf_write_en, rf_write_addr, rf_write_data);
    end
    checks++;
    if (pending !== 32'd0) begin
      errors++;
      $display("FAIL reset_pending: got %h, required 0", pending);
    end
    checks++;
    if (alu_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_alu_stall: got %b, required 0", alu_stall);
    end
    reset = 1'b0;
    step();
    checks++;
    if (lsu_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_lsu_ready: got %b, required 1", lsu_ready);
    end
    $display("reset checks done");
  endtask

  task automatic test_bypass();
    issue_en = 1'b1; issue_rd = 5'd5;
    step();
    issue_en = 1'b0;
    checks++;
    if (pending[5] !== 1'b1) begin
      errors++;
      $display("FAIL bypass_pending_set: got %b, required 1", pending[5]);
    end
    lsu_valid = 1'b1; lsu_rd = 5'd5; lsu_data = 32'hA5A5_0001;
    push_exp(5'd5, 32'hA5A5_0001);
    step();
    lsu_valid = 1'b0;
    checks++;
    if ({rf_write_en, rf_write_addr, rf_write_data} !== {1'b1, 5'd5, 32'hA5A5_0001}) begin
      errors++;
      $display("FAIL bypass_latency: got en=%b x%0d=%h, required en=1 x5=a5a50001", rf_write_en, rf_write_addr, rf_write_data);
    end
    checks++;
    if (pending[5] !== 1'b0) begin
      errors++;
      $display("FAIL bypass_pending_clear: got %b, required 0", pending[5]);
    end
    step();
    $display("bypass scenario done");
  endtask

  task automatic test_conflict();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h22;
    push_exp(5'd3, 32'h11);
    push_exp(5'd4, 32'h22);
    step();
    idle_inputs();
    checks++;
    if ({rf_write_en, rf_write_addr, rf_write_data} !== {1'b1, 5'd3, 32'h11}) begin
      errors++;
      $display("FAIL conflict_alu_first: got en=%b x%0d=%h, required x3=11", rf_write_en, rf_write_addr, rf_write_data);
    end
    step();
    checks++;
    if ({rf_write_en, rf_write_addr, rf_write_data} !== {1'b1, 5'd4, 32'h22}) begin
      errors++;
      $display("FAIL conflict_load_second: got en=%b x%0d=%h, required x4=22", rf_write_en, rf_write_addr, rf_write_data);
    end
    step();
    $display("conflict scenario done");
  endtask

  task automatic test_full_stall();
    int k;
    logic acc;
    k = 0;
    for (int i = 0; i < 3; i++) begin
      issue_en = 1'b1; issue_rd = 5'(10 + i);
      step();
    end
    issue_en = 1'b0;
    for (int c = 0; c < 8; c++) begin
      alu_valid = (c < 4);
      alu_rd    = 5'(20 + c);
      alu_data  = 32'hA000_0000 + 32'(c);
      if (c < 4) push_exp(5'(20 + c), 32'hA000_0000 + 32'(c));
      if (c == 3) begin
        for (int j = 0; j < 3; j++) push_exp(5'(10 + j), 32'hB000_0000 + 32'(j));
      end
      lsu_valid = (k < 3);
      lsu_rd    = 5'(10 + k);
      lsu_data  = 32'hB000_0000 + 32'(k);
      if (c == 2) begin
        checks++;
        if ({k[1:0], lsu_ready, alu_stall} !== {2'd2, 1'b0, 1'b1}) begin
          errors++;
          $display("FAIL full_backpressure: got accepted=%0d ready=%b stall=%b, required 2/0/1", k, lsu_ready, alu_stall);
        end
      end
      acc = lsu_valid && lsu_ready;
      step();
      if (acc) k++;
      if (c >= 4 && c <= 6) begin
        checks++;
        if ({rf_write_en, rf_write_addr} !== {1'b1, 5'(10 + c - 4)}) begin
          errors++;
          $display("FAIL drain_order: cycle %0d got en=%b x%0d, required en=1 x%0d", c, rf_write_en, rf_write_addr, 10 + c - 4);
        end
      end
      if (c == 7) begin
        checks++;
        if (rf_write_en !== 1'b0) begin
          errors++;
          $display("FAIL drain_done: got en=%b, required 0", rf_write_en);
        end
      end
    end
    idle_inputs();
    checks++;
    if (pending[12:10] !== 3'b000) begin
      errors++;
      $display("FAIL drain_pending: got %b, required 000", pending[12:10]);
    end
    $display("full/stall scenario done, accepted=%0d", k);
  endtask

  task automatic test_x0();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
    issue_en  = 1'b1; issue_rd = 5'd0;
    step();
    idle_inputs();
    checks++;
    if (rf_write_en !== 1'b0) begin
      errors++;
      $display("FAIL x0_write: got en=%b, required 0", rf_write_en);
    end
    checks++;
    if (pending !== 32'd0) begin
      errors++;
      $display("FAIL x0_pending: got %h, required 0", pending);
    end
    step();
    $display("x0 scenario done");
  endtask

  task automatic test_pending_race();
    issue_en = 1'b1; issue_rd = 5'd7;
    step();
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h0000_0777;
    push_exp(5'd7, 32'h0000_0777);
    step();
    idle_inputs();
    checks++;
    if ({rf_write_en, rf_write_addr} !== {1'b1, 5'd7}) begin
      errors++;
      $display("FAIL race_write: got en=%b x%0d, required en=1 x7", rf_write_en, rf_write_addr);
    end
    checks++;
    if (pending[7] !== 1'b1) begin
      errors++;
      $display("FAIL race_set_wins: got %b, required 1", pending[7]);
    end
    step();
    $display("pending race scenario done");
  endtask

  task automatic test_reset_mid_op();
    issue_en = 1'b1; issue_rd = 5'd8;
    step();
    issue_rd = 5'd9;
    step();
    issue_en = 1'b0;
    for (int c = 0; c < 2; c++) begin
      alu_valid = 1'b1; alu_rd = 5'(21 + c); alu_data = 32'hC000_0000 + 32'(c);
      push_exp(5'(21 + c), 32'hC000_0000 + 32'(c));
      lsu_valid = 1'b1; lsu_rd = 5'(8 + c); lsu_data = 32'hD000_0000 + 32'(c);
      step();
    end
    idle_inputs();
    checks++;
    if ({alu_stall, pending[9:8]} !== 3'b111) begin
      errors++;
      $display("FAIL pre_reset_state: got stall=%b pending[9:8]=%b, required 1/11", alu_stall, pending[9:8]);
    end
    #4;
    reset = 1'b1;
    step();
    checks++;
    if ({pending, lsu_ready, alu_stall, rf_write_en} !== {32'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset_state: got pending=%h ready=%b stall=%b en=%b, required 0/1/0/0", pending, lsu_ready, alu_stall, rf_write_en);
    end
    #3;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (rf_write_en !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_idle: cycle %0d got en=%b x%0d, required 0", i, rf_write_en, rf_write_addr);
      end
    end
    $display("reset mid-operation scenario done");
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_conflict();
    test_full_stall();
    test_x0();
    test_pending_race();
    test_reset_mid_op();
    step();
    step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d unwritten entries, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
